// File: rtl/jtag_instruction_register_if.sv
// -----------------------------------------------------------------------------
// jtag_instruction_register_if
// Purpose : bundles the TAP-controller strobes, serial data, status input and
//           the decoded instruction outputs of the JTAG instruction register.
// Signals :
//   TAP side  -> IR : TEST_LOGIC_RESET, CAPTURE_IR, SHIFT_IR, UPDATE_IR, TDI,
//                     STATUS[IR_WIDTH-3:0]
//   IR -> DR mux/BSR: TDO, IR_OUT[IR_WIDTH-1:0], G1[1:0], BYPASS_ENABLE,
//                     DEVICE_ID_ENABLE, BSR_ENABLE, MODE_TEST_NORMAL,
//                     CAPTURE_MODE_INPUT, UPDATE_MODE_INPUT,
//                     CAPTURE_MODE_OUTPUT, UPDATE_MODE_OUTPUT, HIGHZ_ENABLE,
//                     ILLEGAL_IR
// Modports: master = TAP controller / consumer side, slave = the IR itself.
// -----------------------------------------------------------------------------
interface jtag_instruction_register_if #(
  parameter int IR_WIDTH = 4
);
  logic                TEST_LOGIC_RESET;
  logic                CAPTURE_IR;
  logic                SHIFT_IR;
  logic                UPDATE_IR;
  logic                TDI;
  logic [IR_WIDTH-3:0] STATUS;

  logic                TDO;
  logic [IR_WIDTH-1:0] IR_OUT;
  logic [1:0]          G1;
  logic                BYPASS_ENABLE;
  logic                DEVICE_ID_ENABLE;
  logic                BSR_ENABLE;
  logic                MODE_TEST_NORMAL;
  logic                CAPTURE_MODE_INPUT;
  logic                UPDATE_MODE_INPUT;
  logic                CAPTURE_MODE_OUTPUT;
  logic                UPDATE_MODE_OUTPUT;
  logic                HIGHZ_ENABLE;
  logic                ILLEGAL_IR;

  modport master (
    output TEST_LOGIC_RESET, CAPTURE_IR, SHIFT_IR, UPDATE_IR, TDI, STATUS,
    input  TDO, IR_OUT, G1, BYPASS_ENABLE, DEVICE_ID_ENABLE, BSR_ENABLE,
           MODE_TEST_NORMAL, CAPTURE_MODE_INPUT, UPDATE_MODE_INPUT,
           CAPTURE_MODE_OUTPUT, UPDATE_MODE_OUTPUT, HIGHZ_ENABLE, ILLEGAL_IR
  );

  modport slave (
    input  TEST_LOGIC_RESET, CAPTURE_IR, SHIFT_IR, UPDATE_IR, TDI, STATUS,
    output TDO, IR_OUT, G1, BYPASS_ENABLE, DEVICE_ID_ENABLE, BSR_ENABLE,
           MODE_TEST_NORMAL, CAPTURE_MODE_INPUT, UPDATE_MODE_INPUT,
           CAPTURE_MODE_OUTPUT, UPDATE_MODE_OUTPUT, HIGHZ_ENABLE, ILLEGAL_IR
  );
endinterface

// File: rtl/jtag_instruction_register.sv
// -----------------------------------------------------------------------------
// jtag_instruction_register
// Purpose : IEEE 1149.1 instruction register. Captures {STATUS, 2'b01},
//           shifts LSB first towards TDO, latches on Update-IR, and decodes
//           the latched instruction into DR select and boundary-scan controls.
// Ports   :
//   TCK  - test clock, all state changes on its rising edge
//   TRST - asynchronous active-low reset (loads IDCODE)
//   bus  - jtag_instruction_register_if.slave: TAP strobes, TDI, STATUS in;
//          TDO, IR_OUT and decoded controls out
// -----------------------------------------------------------------------------
module jtag_instruction_register #(
  parameter int                IR_WIDTH            = 4,
  parameter logic [IR_WIDTH-1:0] CODE_BYPASS         = '1,
  parameter logic [IR_WIDTH-1:0] CODE_SAMPLE_PRELOAD = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] CODE_IDCODE         = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0] CODE_EXTEST         = IR_WIDTH'(4),
  parameter logic [IR_WIDTH-1:0] CODE_INTEST         = IR_WIDTH'(8),
  parameter logic [IR_WIDTH-1:0] CODE_CLAMP          = IR_WIDTH'(3),
  parameter logic [IR_WIDTH-1:0] CODE_HIGHZ          = IR_WIDTH'(5)
) (
  input logic                          TCK,
  input logic                          TRST,
  jtag_instruction_register_if.slave   bus
);

  // Value the shift register takes on any reset: the mandatory 01 capture
  // pattern with zeros above it.
  localparam logic [IR_WIDTH-1:0] SR_RESET = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0] r_sr;
  logic [IR_WIDTH-1:0] r_il;

  logic w_is_bypass, w_is_sample, w_is_idcode, w_is_extest;
  logic w_is_intest, w_is_clamp, w_is_highz, w_is_illegal;
  logic w_bsr_instr;

  // Strobe priority: Test-Logic-Reset > Capture > Shift > Update.
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      r_sr <= SR_RESET;
      r_il <= CODE_IDCODE;
    end else if (bus.TEST_LOGIC_RESET) begin
      r_sr <= SR_RESET;
      r_il <= CODE_IDCODE;
    end else if (bus.CAPTURE_IR) begin
      r_sr <= {bus.STATUS, 2'b01};
    end else if (bus.SHIFT_IR) begin
      r_sr <= {bus.TDI, r_sr[IR_WIDTH-1:1]};
    end else if (bus.UPDATE_IR) begin
      r_il <= r_sr;
    end
  end

  // Decode works on the latch only, so shifting never disturbs the active
  // instruction.
  assign w_is_bypass  = (r_il == CODE_BYPASS);
  assign w_is_sample  = (r_il == CODE_SAMPLE_PRELOAD);
  assign w_is_idcode  = (r_il == CODE_IDCODE);
  assign w_is_extest  = (r_il == CODE_EXTEST);
  assign w_is_intest  = (r_il == CODE_INTEST);
  assign w_is_clamp   = (r_il == CODE_CLAMP);
  assign w_is_highz   = (r_il == CODE_HIGHZ);
  assign w_is_illegal = ~(w_is_bypass | w_is_sample | w_is_idcode | w_is_extest |
                          w_is_intest | w_is_clamp  | w_is_highz);
  assign w_bsr_instr  = w_is_sample | w_is_extest | w_is_intest;

  assign bus.TDO    = r_sr[0];
  assign bus.IR_OUT = r_il;

  // Unknown opcodes fall back to the BYPASS decode (G1 = 0, pins normal).
  assign bus.G1                  = w_bsr_instr ? 2'd1 : (w_is_idcode ? 2'd2 : 2'd0);
  assign bus.BYPASS_ENABLE       = w_is_bypass | w_is_clamp | w_is_highz | w_is_illegal;
  assign bus.DEVICE_ID_ENABLE    = w_is_idcode;
  assign bus.BSR_ENABLE          = w_bsr_instr;
  assign bus.MODE_TEST_NORMAL    = w_is_bypass | w_is_idcode | w_is_sample | w_is_illegal;
  assign bus.CAPTURE_MODE_INPUT  = w_is_extest;
  assign bus.UPDATE_MODE_INPUT   = w_is_sample | w_is_intest;
  assign bus.CAPTURE_MODE_OUTPUT = w_is_intest;
  // CLAMP keeps the pins driven from the BSR update latches while bypass is
  // the selected DR.
  assign bus.UPDATE_MODE_OUTPUT  = w_is_sample | w_is_extest | w_is_clamp;
  assign bus.HIGHZ_ENABLE        = w_is_highz;
  assign bus.ILLEGAL_IR          = w_is_illegal;

endmodule

// File: tb/tb_jtag_instruction_register.sv
// -----------------------------------------------------------------------------
// tb_jtag_instruction_register
// Purpose : directed self-checking bench for jtag_instruction_register, with a
//           4-bit instance and a 6-bit instance sharing TCK/TRST.
// -----------------------------------------------------------------------------
module tb_jtag_instruction_register;

  logic tck;
  logic trst;
  int   n_pass;
  int   n_total;

  jtag_instruction_register_if #(.IR_WIDTH(4)) bus4 ();
  jtag_instruction_register_if #(.IR_WIDTH(6)) bus6 ();

  jtag_instruction_register #(.IR_WIDTH(4)) dut4 (
    .TCK  (tck),
    .TRST (trst),
    .bus  (bus4.slave)
  );

  jtag_instruction_register #(.IR_WIDTH(6), .CODE_BYPASS(6'h3F)) dut6 (
    .TCK  (tck),
    .TRST (trst),
    .bus  (bus6.slave)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Decoded outputs packed as
  // {G1[1:0], BYP, DID, BSR, MTN, CMI, UMI, CMO, UMO, HZ, ILL}
  localparam logic [11:0] D_IDCODE = 12'b10_0_1_0_1_0_0_0_0_0_0;
  localparam logic [11:0] D_BYPASS = 12'b00_1_0_0_1_0_0_0_0_0_0;
  localparam logic [11:0] D_SAMPLE = 12'b01_0_0_1_1_0_1_0_1_0_0;
  localparam logic [11:0] D_EXTEST = 12'b01_0_0_1_0_1_0_0_1_0_0;
  localparam logic [11:0] D_INTEST = 12'b01_0_0_1_0_0_1_1_0_0_0;
  localparam logic [11:0] D_CLAMP  = 12'b00_1_0_0_0_0_0_0_1_0_0;
  localparam logic [11:0] D_HIGHZ  = 12'b00_1_0_0_0_0_0_0_0_1_0;
  localparam logic [11:0] D_ILLEG  = 12'b00_1_0_0_1_0_0_0_0_0_1;

  function automatic logic [11:0] dec4();
    return {bus4.G1, bus4.BYPASS_ENABLE, bus4.DEVICE_ID_ENABLE, bus4.BSR_ENABLE,
            bus4.MODE_TEST_NORMAL, bus4.CAPTURE_MODE_INPUT, bus4.UPDATE_MODE_INPUT,
            bus4.CAPTURE_MODE_OUTPUT, bus4.UPDATE_MODE_OUTPUT, bus4.HIGHZ_ENABLE,
            bus4.ILLEGAL_IR};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic capture4(input logic [1:0] st);
    bus4.STATUS     = st;
    bus4.CAPTURE_IR = 1'b1;
    tick();
    bus4.CAPTURE_IR = 1'b0;
  endtask

  task automatic shift4(input logic [3:0] v, input int n);
    bus4.SHIFT_IR = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus4.TDI = v[i];
      tick();
    end
    bus4.SHIFT_IR = 1'b0;
    bus4.TDI      = 1'b0;
  endtask

  task automatic update4();
    bus4.UPDATE_IR = 1'b1;
    tick();
    bus4.UPDATE_IR = 1'b0;
  endtask

  task automatic load4(input logic [3:0] code);
    capture4(2'b00);
    shift4(code, 4);
    update4();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    trst    = 1'b0;
    bus4.TEST_LOGIC_RESET = 1'b0; bus4.CAPTURE_IR = 1'b0; bus4.SHIFT_IR = 1'b0;
    bus4.UPDATE_IR = 1'b0; bus4.TDI = 1'b0; bus4.STATUS = '0;
    bus6.TEST_LOGIC_RESET = 1'b0; bus6.CAPTURE_IR = 1'b0; bus6.SHIFT_IR = 1'b0;
    bus6.UPDATE_IR = 1'b0; bus6.TDI = 1'b0; bus6.STATUS = '0;

    // Reset
    repeat (2) tick();
    trst = 1'b1;
    tick();
    chk("reset_ir_out", 32'(bus4.IR_OUT), 32'h2);
    chk("reset_decode", 32'(dec4()), 32'(D_IDCODE));
    chk("reset_tdo", 32'(bus4.TDO), 32'h1);
    $display("txn reset: IR_OUT=%0h TDO=%0b", bus4.IR_OUT, bus4.TDO);

    // Capture STATUS=10 then shift out 1,0,0,1
    capture4(2'b10);
    chk("cap_tdo0", 32'(bus4.TDO), 32'h1);
    shift4(4'h0, 1);
    chk("cap_tdo1", 32'(bus4.TDO), 32'h0);
    shift4(4'h0, 1);
    chk("cap_tdo2", 32'(bus4.TDO), 32'h0);
    shift4(4'h0, 1);
    chk("cap_tdo3", 32'(bus4.TDO), 32'h1);
    shift4(4'h0, 1);
    chk("cap_ir_hold", 32'(bus4.IR_OUT), 32'h2);
    $display("txn capture/shift-out: IR_OUT=%0h", bus4.IR_OUT);

    // EXTEST, with the old decode still visible before the update edge
    capture4(2'b00);
    shift4(4'h4, 4);
    chk("extest_pre_ir", 32'(bus4.IR_OUT), 32'h2);
    chk("extest_pre_dec", 32'(dec4()), 32'(D_IDCODE));
    update4();
    chk("extest_ir", 32'(bus4.IR_OUT), 32'h4);
    chk("extest_dec", 32'(dec4()), 32'(D_EXTEST));
    $display("txn load EXTEST: IR_OUT=%0h dec=%b", bus4.IR_OUT, dec4());

    // Remaining opcodes
    load4(4'hF);
    chk("bypass_ir", 32'(bus4.IR_OUT), 32'hF);
    chk("bypass_dec", 32'(dec4()), 32'(D_BYPASS));
    $display("txn load BYPASS: IR_OUT=%0h dec=%b", bus4.IR_OUT, dec4());
    load4(4'h1);
    chk("sample_dec", 32'(dec4()), 32'(D_SAMPLE));
    $display("txn load SAMPLE: IR_OUT=%0h dec=%b", bus4.IR_OUT, dec4());
    load4(4'h8);
    chk("intest_dec", 32'(dec4()), 32'(D_INTEST));
    $display("txn load INTEST: IR_OUT=%0h dec=%b", bus4.IR_OUT, dec4());
    load4(4'h3);
    chk("clamp_dec", 32'(dec4()), 32'(D_CLAMP));
    $display("txn load CLAMP: IR_OUT=%0h dec=%b", bus4.IR_OUT, dec4());
    load4(4'h5);
    chk("highz_dec", 32'(dec4()), 32'(D_HIGHZ));
    $display("txn load HIGHZ: IR_OUT=%0h dec=%b", bus4.IR_OUT, dec4());
    load4(4'hA);
    chk("illegal_ir", 32'(bus4.IR_OUT), 32'hA);
    chk("illegal_dec", 32'(dec4()), 32'(D_ILLEG));
    $display("txn load 0xA: IR_OUT=%0h dec=%b", bus4.IR_OUT, dec4());

    // CAPTURE and SHIFT together: capture of {11,01} wins, shift ignored
    bus4.STATUS     = 2'b11;
    bus4.CAPTURE_IR = 1'b1;
    bus4.SHIFT_IR   = 1'b1;
    bus4.TDI        = 1'b0;
    tick();
    bus4.CAPTURE_IR = 1'b0;
    bus4.SHIFT_IR   = 1'b0;
    chk("prio_cap_tdo0", 32'(bus4.TDO), 32'h1);
    shift4(4'h0, 1);
    chk("prio_cap_tdo1", 32'(bus4.TDO), 32'h0);
    shift4(4'h0, 1);
    chk("prio_cap_tdo2", 32'(bus4.TDO), 32'h1);
    $display("txn capture+shift same edge: TDO=%0b", bus4.TDO);

    // TEST_LOGIC_RESET beats UPDATE_IR (SR holds 8 at that point)
    capture4(2'b00);
    shift4(4'h8, 4);
    bus4.TEST_LOGIC_RESET = 1'b1;
    bus4.UPDATE_IR        = 1'b1;
    tick();
    bus4.TEST_LOGIC_RESET = 1'b0;
    bus4.UPDATE_IR        = 1'b0;
    chk("tlr_ir_out", 32'(bus4.IR_OUT), 32'h2);
    chk("tlr_tdo", 32'(bus4.TDO), 32'h1);
    $display("txn TLR+UPDATE: IR_OUT=%0h", bus4.IR_OUT);

    // TRST asynchronously mid-shift of 0x8
    load4(4'hF);
    capture4(2'b00);
    shift4(4'h8, 2);
    trst = 1'b0;
    #1;
    chk("trst_mid_ir", 32'(bus4.IR_OUT), 32'h2);
    chk("trst_mid_tdo", 32'(bus4.TDO), 32'h1);
    #1;
    trst = 1'b1;
    // SR must now be 0001: shift out 1,0,0,0
    shift4(4'h0, 1);
    chk("trst_sr_b1", 32'(bus4.TDO), 32'h0);
    shift4(4'h0, 2);
    chk("trst_sr_b3", 32'(bus4.TDO), 32'h0);
    shift4(4'h0, 1);
    update4();
    chk("trst_no_intest", 32'(bus4.IR_OUT), 32'h0);
    chk("trst_no_intest_dec", 32'(dec4()), 32'(D_ILLEG));
    $display("txn TRST mid-shift: IR_OUT=%0h", bus4.IR_OUT);

    // 6-bit instance: capture 1011_01, shift out while shifting in ones
    chk("w6_reset_ir", 32'(bus6.IR_OUT), 32'h02);
    bus6.STATUS     = 4'hB;
    bus6.CAPTURE_IR = 1'b1;
    tick();
    bus6.CAPTURE_IR = 1'b0;
    bus6.SHIFT_IR   = 1'b1;
    bus6.TDI        = 1'b1;
    begin
      logic [5:0] exp_bits;
      exp_bits = 6'b101101;
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("w6_tdo%0d", i), 32'(bus6.TDO), 32'(exp_bits[i]));
        tick();
      end
    end
    bus6.SHIFT_IR  = 1'b0;
    bus6.UPDATE_IR = 1'b1;
    tick();
    bus6.UPDATE_IR = 1'b0;
    chk("w6_ir_out", 32'(bus6.IR_OUT), 32'h3F);
    chk("w6_bypass_en", 32'(bus6.BYPASS_ENABLE), 32'h1);
    chk("w6_illegal", 32'(bus6.ILLEGAL_IR), 32'h0);
    $display("txn width6 BYPASS: IR_OUT=%0h BYPASS_ENABLE=%0b", bus6.IR_OUT, bus6.BYPASS_ENABLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jtag_instruction_register.md
Name: jtag_instruction_register

Overview:
- Parametrised JTAG instruction register with an integrated, registered instruction decoder.
- Captures, shifts and updates the IR under control of the TAP controller's state strobes, then decodes the latched instruction into data-register select and boundary-scan mode controls.
- Generalises the fixed 4-bit decoder to IR_WIDTH bits with configurable opcodes, and adds CLAMP, HIGHZ and illegal-opcode detection.
- Sits between the TAP controller and the DR mux / boundary-scan cells.

Parameters:
- IR_WIDTH, 4: instruction register length in bits; must be at least 3.
- CODE_BYPASS, all ones: BYPASS opcode.
- CODE_SAMPLE_PRELOAD, 1: SAMPLE/PRELOAD opcode.
- CODE_IDCODE, 2: IDCODE opcode; also the value loaded at reset.
- CODE_EXTEST, 4: EXTEST opcode.
- CODE_INTEST, 8: INTEST opcode.
- CODE_CLAMP, 3: CLAMP opcode.
- CODE_HIGHZ, 5: HIGHZ opcode.
- All opcode parameters must be distinct. Every opcode is IR_WIDTH bits wide.

Ports:
- TCK  in  1  test clock; all state updates on its rising edge.
- TRST  in  1  asynchronous active-low reset.
- TEST_LOGIC_RESET  in  1  TAP controller is in Test-Logic-Reset; acts as a synchronous reset.
- CAPTURE_IR  in  1  TAP controller is in Capture-IR.
- SHIFT_IR  in  1  TAP controller is in Shift-IR.
- UPDATE_IR  in  1  TAP controller is in Update-IR.
- TDI  in  1  serial data in.
- STATUS  in  IR_WIDTH-2  design status bits loaded on capture.
- TDO  out  1  serial IR data out; equals shift register bit 0 (combinational).
- IR_OUT  out  IR_WIDTH  latched instruction, raw value.
- G1  out  2  DR select: 0 = bypass, 1 = BSR, 2 = device ID.
- BYPASS_ENABLE  out  1  bypass DR selected.
- DEVICE_ID_ENABLE  out  1  IDCODE DR selected.
- BSR_ENABLE  out  1  boundary-scan register selected.
- MODE_TEST_NORMAL  out  1  1 = core pins operate normally; 0 = test mode.
- CAPTURE_MODE_INPUT  out  1  BSR captures input pins.
- UPDATE_MODE_INPUT  out  1  BSR update drives core inputs.
- CAPTURE_MODE_OUTPUT  out  1  BSR captures core outputs.
- UPDATE_MODE_OUTPUT  out  1  BSR update drives output pins.
- HIGHZ_ENABLE  out  1  all output pins tri-stated.
- ILLEGAL_IR  out  1  latched opcode matches no defined instruction.

Behaviour:
- State consists of the shift register SR (IR_WIDTH bits) and the instruction latch IL (IR_WIDTH bits). All decoded outputs are combinational from IL only; they are never derived from SR.
- TRST low (async): SR = {0..0,2'b01}, IL = CODE_IDCODE.
- Reset output values follow from IL = CODE_IDCODE:
  - G1 = 2, DEVICE_ID_ENABLE = 1, MODE_TEST_NORMAL = 1.
  - TDO = 1.
  - All other decoded outputs = 0.
- Per-edge priority when TRST is high: TEST_LOGIC_RESET > CAPTURE_IR > SHIFT_IR > UPDATE_IR. The lower-priority strobes are ignored that edge.
  - TEST_LOGIC_RESET: same effect as TRST, applied synchronously.
  - CAPTURE_IR: SR <= {STATUS, 2'b01}. The two LSBs are fixed at 01 per IEEE 1149.1.
  - SHIFT_IR: SR <= {TDI, SR[IR_WIDTH-1:1]}. LSB first out on TDO.
  - UPDATE_IR: IL <= SR. Decoded outputs change in the same cycle IL changes, i.e. valid from the first edge after UPDATE_IR is sampled high.
  - No strobe: SR and IL hold.
- SR never alters IL except through UPDATE_IR. Shifting therefore leaves the active instruction in force.
- Shift counts are not checked. Shifting more than IR_WIDTH bits keeps only the last IR_WIDTH bits; shifting fewer leaves capture bits in the low positions.
- Decode table (outputs not listed are 0):
  - BYPASS: G1 = 0, BYPASS_ENABLE, MODE_TEST_NORMAL.
  - IDCODE: G1 = 2, DEVICE_ID_ENABLE, MODE_TEST_NORMAL.
  - SAMPLE_PRELOAD: G1 = 1, BSR_ENABLE, MODE_TEST_NORMAL, UPDATE_MODE_INPUT, UPDATE_MODE_OUTPUT.
  - EXTEST: G1 = 1, BSR_ENABLE, CAPTURE_MODE_INPUT, UPDATE_MODE_OUTPUT.
  - INTEST: G1 = 1, BSR_ENABLE, CAPTURE_MODE_OUTPUT, UPDATE_MODE_INPUT.
  - CLAMP: G1 = 0, BYPASS_ENABLE, UPDATE_MODE_OUTPUT. Pins are held from the BSR update latches while bypass is selected.
  - HIGHZ: G1 = 0, BYPASS_ENABLE, HIGHZ_ENABLE.
  - Any other value: decoded exactly as BYPASS, plus ILLEGAL_IR = 1. IR_OUT still shows the raw value.
- Reset asserted mid-shift or mid-update: SR and IL are restored immediately. Any partially shifted instruction is discarded.

Test Plan:
- Reset: TRST pulsed low, no strobes -> IR_OUT = 4'h2, G1 = 2, DEVICE_ID_ENABLE = 1, MODE_TEST_NORMAL = 1, TDO = 1, ILLEGAL_IR = 0.
- Capture/shift-out: STATUS = 2'b10, one CAPTURE_IR, then 4 SHIFT_IR edges with TDI = 0 -> TDO sequence 1, 0, 0, 1; IR_OUT unchanged (4'h2) throughout.
- Load EXTEST: capture, shift TDI = 0, 0, 1, 0 (LSB first), UPDATE_IR -> IR_OUT = 4'h4, G1 = 1, BSR_ENABLE = 1, CAPTURE_MODE_INPUT = 1, UPDATE_MODE_OUTPUT = 1, MODE_TEST_NORMAL = 0. Outputs still show IDCODE decoding before the update edge.
- Each remaining opcode via the same shift/update sequence:
  - 4'hF / 4'h1 / 4'h8: outputs per the decode table.
  - 4'h3 (CLAMP): G1 = 0, BYPASS_ENABLE = 1, UPDATE_MODE_OUTPUT = 1.
  - 4'h5 (HIGHZ): HIGHZ_ENABLE = 1, MODE_TEST_NORMAL = 0.
  - 4'hA (undefined): BYPASS decoding, ILLEGAL_IR = 1, IR_OUT = 4'hA.
- Priority and reset mid-operation:
  - CAPTURE_IR and SHIFT_IR high on the same edge -> capture only.
  - TEST_LOGIC_RESET high with UPDATE_IR -> IR_OUT = 4'h2.
  - TRST low after 2 of 4 shifts of 4'h8 -> IL = 4'h2, SR = 4'b0001, no INTEST ever decoded.
- Width: IR_WIDTH = 6 with CODE_BYPASS = 6'h3F, STATUS = 4'hB -> capture shifts out 1, 0, 1, 1, 0, 1; shifting 6 ones then UPDATE_IR -> BYPASS_ENABLE = 1.
